// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier among NREQ requesters (IDLE->LOAD->WAIT->DONE).
// Optional macro ARB_TIMEOUT_EN bounds WAIT to TMAX cycles and sets a sticky timeout_err.
module booth_mul_arbiter #(
    parameter int NREQ = 2,
    parameter int W    = 3,
    parameter int TMAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] mcando_in,
    input  logic [NREQ*W-1:0] mcador_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [2*W-1:0]    resultado,
    output logic              mul_start,
    output logic [W-1:0]      mul_mcando,
    output logic [W-1:0]      mul_mcador,
    input  logic [2*W-1:0]    mul_producto,
    input  logic              mul_fin,
    output logic              busy,
    output logic              timeout_err
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IW-1:0]  r_ptr;
    logic [IW-1:0]  r_owner;
    logic [IW-1:0]  w_win;
    logic           w_found;
    logic [W-1:0]   r_mcando;
    logic [W-1:0]   r_mcador;
    logic [2*W-1:0] r_res;
    logic           r_fin_q;
    logic           w_fin_rise;
    logic           w_tmo;

    // Search starts just after the last owner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    // Only a fresh rising edge completes; a fin level left over from the last job is ignored.
    assign w_fin_rise = (r_state == WAIT) && mul_fin && !r_fin_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMAX + 1);

    logic [CW-1:0] r_cnt;
    logic          r_terr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_terr <= 1'b0;
        end else begin
            if (r_state == LOAD) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_tmo && !w_fin_rise) begin
                r_terr <= 1'b1;
            end
        end
    end

    assign w_tmo       = (r_state == WAIT) && ((int'(r_cnt) + 1) == TMAX);
    assign timeout_err = r_terr;
`else
    logic w_unused_tmax;

    assign w_unused_tmax = (TMAX > 0);
    assign w_tmo         = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= IW'(NREQ - 1);
            r_owner  <= '0;
            r_mcando <= '0;
            r_mcador <= '0;
            r_res    <= '0;
            r_fin_q  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fin_q <= mul_fin;
            if ((r_state == IDLE) && w_found) begin
                r_owner  <= w_win;
                r_mcando <= mcando_in[int'(w_win)*W +: W];
                r_mcador <= mcador_in[int'(w_win)*W +: W];
            end
            if (r_state == LOAD) begin
                r_ptr <= r_owner;
            end
            if (w_fin_rise) begin
                r_res <= mul_producto;
            end else if (w_tmo) begin
                r_res <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        gnt         = '0;
        done        = '0;
        mul_start   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_found) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                gnt[r_owner] = 1'b1;
                mul_start    = 1'b1;
                w_state_nxt  = WAIT;
            end
            WAIT: begin
                if (w_fin_rise || w_tmo) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done[r_owner] = 1'b1;
                w_state_nxt   = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign mul_mcando = r_mcando;
    assign mul_mcador = r_mcador;
    assign resultado  = r_res;

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

- Shares one Booth multiplier datapath/control pair between up to four requesters.
- Arbitrates pending requests round-robin and drives the multiplier's operands and `start`.
- Waits for the multiplier's `fin`, captures the product, and returns it to the granted requester with a done pulse.
- Sits between the requesting units and the single multiplier instance; it owns all of the multiplier's inputs.

## Interface
Parameters:
- NREQ, 2, number of requesters (legal 2..4)
- W, 3, operand width; product is 2*W
- TMAX, 15, timeout limit in cycles spent in WAIT (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  request per requester; held high with operands stable until its gnt
- mcando_in  in  NREQ*W  multiplicand per requester, slice i = [i*W +: W]
- mcador_in  in  NREQ*W  multiplier per requester, same slicing
- gnt  out  NREQ  one-hot, one-cycle pulse; operands of that requester latched
- done  out  NREQ  one-hot, one-cycle pulse; resultado valid for that requester
- resultado  out  2*W  last product, held until next DONE
- mul_start  out  1  to multiplier start
- mul_mcando  out  W  to multiplier multiplicand (registered)
- mul_mcador  out  W  to multiplier multiplier (registered)
- mul_producto  in  2*W  from multiplier product
- mul_fin  in  1  from multiplier fin
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, LOAD, WAIT, DONE.
- **IDLE**
  - If any req is high, select the winner round-robin: first requester with req high searching from ptr+1 upward, wrapping modulo NREQ.
  - Latch the winner's operands into mul_mcando/mul_mcador, record the owner index, go to LOAD.
- **LOAD** (exactly 1 cycle)
  - gnt[owner]=1 and mul_start=1.
  - ptr <= owner.
  - Go to WAIT.
- **WAIT**
  - Complete on a rising edge of mul_fin: mul_fin=1 with the registered mul_fin_q=0. A mul_fin level already high on entry is ignored.
  - On completion, capture resultado <= mul_producto and go to DONE.
- **DONE** (exactly 1 cycle)
  - done[owner]=1, then go to IDLE.
- Requests are sampled only in IDLE. A req dropped before its gnt is simply lost. A req is never preempted.
- Operands stay stable on mul_mcando/mul_mcador from LOAD through DONE.
- Product is passed through unmodified: two's-complement, 2*W bits.
- Reset values: state IDLE, ptr NREQ-1 (so requester 0 wins first), gnt 0, done 0, mul_start 0, mul_mcando 0, mul_mcador 0, resultado 0, busy 0, timeout_err 0, mul_fin_q 0.
- Reset mid-operation: everything returns to the reset values immediately.
  - No done is issued for the aborted transaction.
  - The multiplier itself has no reset; the next mul_start restarts it.

## Timing
- req high in IDLE at edge n: gnt and mul_start high in cycle n+1 (LOAD).
- WAIT is entered at n+2.
- A mul_fin rising edge seen at edge m: done and the new resultado are visible in cycle m+1.
- Back-to-back: DONE -> IDLE -> LOAD. Minimum spacing between successive gnt pulses is 4 cycles plus the multiplier latency.
- gnt and done are never high in the same cycle. At most one bit of each is set.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TMAX with no fin edge: go to DONE with resultado=0 and done[owner] pulsed.
  - timeout_err is set and stays set until rst_n.
- Undefined: WAIT lasts indefinitely, no counter is synthesized, and timeout_err is tied to 0.

## Test plan
- Single request, NREQ=2, W=3, requester 0: 3'b011 x 3'b010 -> gnt[0] one cycle after req, done[0] with resultado=6'b000110.
- Signed operands, requester 1: 3'b101 x 3'b011 (-3x3) -> done[1] with resultado=6'b110111 (-9). Also -4 x -4 -> 6'b010000.
- req=2'b11 held continuously from reset -> grant order 0,1,0,1 over four transactions; each done matches its own requester's operands.
- rst_n pulsed low during WAIT -> busy, gnt, done and mul_start all 0 immediately; no done for the aborted transaction. A new req after release completes correctly.
- mul_fin already high when WAIT is entered (stub multiplier) -> no completion until fin falls and rises again.
- With ARB_TIMEOUT_EN and a stub that never raises fin: done[owner] TMAX+1 cycles after gnt, resultado=0, timeout_err=1 and held. Without the macro: no done, timeout_err=0.
